// File: rtl/bet_ledger_if.sv
// Bet-ledger bus: keyboard/colour/payout inputs toward the ledger and the
// captured bet bus plus status flags back toward the register file.
interface bet_ledger_if #(
  parameter int MAX_BETS = 12,
  parameter int OP_W     = 6,
  parameter int COLOR_W  = 2
);
  localparam int W  = OP_W + COLOR_W;
  localparam int CW = $clog2(MAX_BETS + 1);

  // key_valid is a level; only its rising edge counts as a request. There is
  // no ready: the ledger accepts or refuses each event, and a refusal shows
  // up as a one-cycle reject pulse.
  logic                    key_valid;
  logic [OP_W-1:0]         key_opcode;
  logic [COLOR_W:0]        color_in;
  logic                    spin_done;
  logic [MAX_BETS*W-1:0]   bets_flat;
  logic [CW-1:0]           bet_count;
  logic                    spin_active;
  logic                    full;
  logic                    reject;
  logic                    overflow;

  modport master (
    output key_valid, key_opcode, color_in, spin_done,
    input  bets_flat, bet_count, spin_active, full, reject, overflow
  );

  modport slave (
    input  key_valid, key_opcode, color_in, spin_done,
    output bets_flat, bet_count, spin_active, full, reject, overflow
  );
endinterface

// File: rtl/bet_ledger.sv
// Bet-capture ledger: turns keyboard strobes into {colour, opcode} entries,
// supports undo, and locks during a spin until the payout is settled.
module bet_ledger #(
  parameter int              MAX_BETS = 12,
  parameter int              OP_W     = 6,
  parameter int              COLOR_W  = 2,
  parameter logic [OP_W-1:0] SPIN_OP  = 6'b111110,
  parameter logic [OP_W-1:0] IDLE_OP  = 6'b111111,
  parameter logic [OP_W-1:0] UNDO_OP  = 6'b111101
) (
  input  logic         clock,
  input  logic         reset,
  bet_ledger_if.slave  bus,
  output logic [1:0]   state_dbg
);
  localparam int W  = OP_W + COLOR_W;
  localparam int CW = $clog2(MAX_BETS + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_BETS);

  typedef enum logic [1:0] {
    OPEN   = 2'd0,
    LOCKED = 2'd1,
    SETTLE = 2'd2
  } state_t;

  state_t state, state_next;

  // Inputs are registered first so every output is a pure register output.
  logic              key_r, key_q, done_r;
  logic [OP_W-1:0]   op_r;
  logic [COLOR_W:0]  col_r;
  logic              key_event;

  logic [W-1:0]  slots [MAX_BETS];
  logic [CW-1:0] count, count_next, count_m1;
  logic          overflow_r, overflow_next;
  logic          reject_r, reject_next;
  logic          full_r, spin_r;
  logic          wr_en, undo_en, wipe;
  logic [W-1:0]  wdata;

  assign key_event = key_r & ~key_q;
  assign count_m1  = count - CW'(1);
  assign wdata     = {col_r[COLOR_W-1:0], op_r};

  always_ff @(posedge clock) begin
    if (reset) begin
      key_r  <= 1'b0;
      key_q  <= 1'b0;
      done_r <= 1'b0;
      op_r   <= '0;
      col_r  <= '0;
    end else begin
      key_r  <= bus.key_valid;
      key_q  <= key_r;
      done_r <= bus.spin_done;
      op_r   <= bus.key_opcode;
      col_r  <= bus.color_in;
    end
  end

  always_comb begin
    state_next    = state;
    count_next    = count;
    overflow_next = overflow_r;
    reject_next   = 1'b0;
    wr_en         = 1'b0;
    undo_en       = 1'b0;
    wipe          = 1'b0;
    case (state)
      OPEN: begin
        if (key_event) begin
          if (op_r == IDLE_OP) begin
            reject_next = 1'b0;
          end else if (op_r == UNDO_OP) begin
            if (count != '0) begin
              undo_en    = 1'b1;
              count_next = count_m1;
            end else begin
              reject_next = 1'b1;
            end
          end else if (op_r == SPIN_OP) begin
            if (count != '0) state_next  = LOCKED;
            else             reject_next = 1'b1;
          end else if (col_r == '0) begin
            reject_next = 1'b1;
          end else if (count == MAX_C) begin
            reject_next   = 1'b1;
            overflow_next = 1'b1;
          end else begin
            wr_en      = 1'b1;
            count_next = count + CW'(1);
          end
        end
      end
      LOCKED: begin
        if (done_r) state_next = SETTLE;
      end
      SETTLE: begin
        wipe          = 1'b1;
        count_next    = '0;
        overflow_next = 1'b0;
        state_next    = OPEN;
      end
      default: state_next = OPEN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= OPEN;
      count      <= '0;
      overflow_r <= 1'b0;
      reject_r   <= 1'b0;
      full_r     <= 1'b0;
      spin_r     <= 1'b0;
    end else begin
      state      <= state_next;
      count      <= count_next;
      overflow_r <= overflow_next;
      reject_r   <= reject_next;
      full_r     <= (count_next == MAX_C);
      spin_r     <= (state_next == LOCKED);
    end
  end

  // Writes and undo keep every slot at or above bet_count at zero.
  always_ff @(posedge clock) begin
    for (int i = 0; i < MAX_BETS; i++) begin
      if (reset || wipe) begin
        slots[i] <= '0;
      end else if (wr_en && (CW'(i) == count)) begin
        slots[i] <= wdata;
      end else if (undo_en && (CW'(i) == count_m1)) begin
        slots[i] <= '0;
      end
    end
  end

  for (genvar g = 0; g < MAX_BETS; g++) begin : g_flat
    assign bus.bets_flat[g*W +: W] = slots[g];
  end

  assign bus.bet_count   = count;
  assign bus.spin_active = spin_r;
  assign bus.full        = full_r;
  assign bus.reject      = reject_r;
  assign bus.overflow    = overflow_r;
  assign state_dbg       = state;
endmodule

// File: doc/bet_ledger.md
# bet_ledger

Parametrised bet-capture ledger between the PS/2 opcode decoder, the Arduino chip-colour inputs and the register file. Each keyboard strobe becomes exactly one bet entry of {colour, opcode}, up to MAX_BETS entries. The ledger supports undo and rejects full, empty and invalid requests. It locks during a spin and clears itself when the processor signals that the payout is settled. It drives the flattened bet bus and the spin flag that the regfile consumes.

## Interface
Parameters:
- MAX_BETS, 12, number of bet slots (1..63)
- OP_W, 6, opcode width
- COLOR_W, 2, stored colour width
- SPIN_OP, 6'b111110, opcode that requests a spin
- IDLE_OP, 6'b111111, "no key" opcode, never stored
- UNDO_OP, 6'b111101, removes the most recent bet

Ports:
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- key_valid  in  1  keyboard data-ready level; only its rising edge is an event
- key_opcode  in  OP_W  decoded opcode, sampled on the key_valid rising-edge cycle
- color_in  in  COLOR_W+1  chip colour; 0 = no chip present; low COLOR_W bits are stored
- spin_done  in  1  processor pulse: payout finished
- bets_flat  out  MAX_BETS*(OP_W+COLOR_W)  slot i at bits [(i+1)*W-1 : i*W], with W = OP_W+COLOR_W; each entry is {colour, opcode}
- bet_count  out  CW  number of valid entries, where CW = $clog2(MAX_BETS+1)
- spin_active  out  1  high while the ledger is in LOCKED
- full  out  1  bet_count == MAX_BETS
- reject  out  1  one-cycle pulse when an event is refused
- overflow  out  1  sticky; set when a bet is refused because the ledger is full

## Operation
- Edge detect: key_q is key_valid registered, reset to 0. event = key_valid & ~key_q.
- States: OPEN, LOCKED, SETTLE.

OPEN, on each event, decode key_opcode:
- Bet: opcode is not SPIN_OP, IDLE_OP or UNDO_OP, and color_in != 0.
  - Not full: write slot[bet_count] = {color_in[COLOR_W-1:0], key_opcode}; bet_count++.
  - Full: reject pulse; set overflow.
- Bet attempt with color_in == 0: reject pulse; ledger unchanged.
- UNDO_OP:
  - bet_count > 0: bet_count--; the vacated slot is zeroed.
  - bet_count == 0: reject pulse.
- SPIN_OP:
  - bet_count > 0: go to LOCKED.
  - bet_count == 0: reject pulse; stay in OPEN.
- IDLE_OP: ignored; no reject.

LOCKED:
- spin_active = 1.
- All key events are ignored with no reject pulse.
- spin_done: go to SETTLE.

SETTLE (one cycle):
- Zero all slots, clear bet_count, clear overflow.
- Go to OPEN.

Other rules:
- spin_done in OPEN or SETTLE is ignored.
- Slots at index >= bet_count always read as zero.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Timing
- Reset values: state OPEN, every slot 0, bet_count 0, spin_active 0, full 0, reject 0, overflow 0, key_q 0.
- Reset mid-spin: returns to OPEN with an empty ledger on the next edge. Reset overrides spin_done and key events in the same cycle.
- Capture latency: key_valid first sampled high at edge N, then:
  - slot, bet_count and full update at edge N+1;
  - reject, if any, is high for the cycle after edge N+1.
- A key held high produces a single event. A new event needs key_valid to be low for at least one sampled cycle.
- Spin latency:
  - SPIN_OP event at edge N: spin_active rises after edge N+1.
  - spin_done sampled at edge M: SETTLE entered after M+1; spin_active falls after M+1; ledger clear and OPEN after M+2.
- Events arriving during the SETTLE cycle are ignored; key_q still tracks key_valid.
- bet_count never wraps in either direction. Full and empty refusals are the only boundary behaviour.
- Throughput: at most one event is processed per two clocks, limited by the key edge spacing.

## Test plan
- Capture: reset; events for opcodes 0x05 (colour 3'b001), 0x12 (colour 3'b010), 0x20 (colour 3'b011) -> bet_count = 3; slot0 = 8'h45, slot1 = 8'h92, slot2 = 8'hE0; key_valid held 10 cycles gives only one entry.
- Full: MAX_BETS = 12; 13 valid bets -> bet_count = 12, full = 1; the 13th produces a reject pulse, sets overflow, and leaves slot11 unchanged.
- Undo and empty: 2 bets, then 3 UNDO_OP events -> bet_count goes 1, then 0, and the third UNDO produces a reject; slot1 and slot0 read zero.
- Spin gating:
  - SPIN_OP with bet_count 0 -> reject pulse, spin_active stays 0.
  - With 4 bets -> spin_active = 1; a bet event during LOCKED leaves bet_count = 4 with no reject.
  - spin_done -> ledger cleared 2 cycles later and overflow cleared.
- Colour missing: bet with color_in = 0 -> reject pulse, bet_count unchanged. IDLE_OP event -> no reject, no change.
- Reset mid-spin: assert reset while LOCKED with 5 bets, simultaneous with spin_done -> next cycle state OPEN, bet_count 0, spin_active 0, all slots zero.
